// File: rtl/io_irq_if.sv
// CPU-side connection of io_irq: the I/O port bus shared with the port decoder,
// the peripheral event pulses and the request/acknowledge/return handshake.
interface io_irq_if;
    logic [15:0] a;
    logic [7:0]  o;
    logic        r;
    logic        w;
    logic [7:0]  p;
    logic [2:0]  ev;
    logic        irq;
    logic [1:0]  vect;
    logic        ack;
    logic        reti;

    modport master (output a, o, r, w, ev, ack, reti, input p, irq, vect);
    modport slave  (input a, o, r, w, ev, ack, reti, output p, irq, vect);
endinterface

// File: rtl/io_irq.sv
// Four-source fixed-priority interrupt controller on the AVR I/O port space
// (IMASK 23h, IPEND 24h, ICTRL 25h) with a 100 Hz internal tick as source 0.
module io_irq #(
    parameter int unsigned TICK_DIV = 250000
) (
    input logic      clock,
    input logic      reset_n,
    io_irq_if.slave  bus
);
    localparam logic [15:0] A_IMASK   = 16'h0023;
    localparam logic [15:0] A_IPEND   = 16'h0024;
    localparam logic [15:0] A_ICTRL   = 16'h0025;
    localparam logic [17:0] TICK_LAST = 18'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] tick_q, tick_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  pend_q, pend_d;
    logic        en_q, en_d;
    logic [1:0]  vect_q, vect_d;
    logic        irq_q, irq_d;

    logic        tick_wrap;
    logic [3:0]  cand;
    logic [1:0]  sel;
    logic        withdraw;
    logic [3:0]  sw_clr;
    logic [3:0]  ack_clr;
    logic        wr_mask, wr_pend, wr_ctrl;
    logic        unused_bus;

    // The read strobe is not needed: reads are side-effect free and p decodes a alone.
    assign unused_bus = ^{bus.r, bus.o[7:4]};

    assign tick_wrap = (tick_q == TICK_LAST);
    assign tick_d    = tick_wrap ? '0 : tick_q + 18'd1;

    assign wr_mask = bus.w && (bus.a == A_IMASK);
    assign wr_pend = bus.w && (bus.a == A_IPEND);
    assign wr_ctrl = bus.w && (bus.a == A_ICTRL);

    assign cand     = pend_q & mask_q & {4{en_q}};
    assign withdraw = !pend_q[vect_q] || !mask_q[vect_q] || !en_q;

    always_comb begin
        sel = 2'd3;
        if (cand[0])      sel = 2'd0;
        else if (cand[1]) sel = 2'd1;
        else if (cand[2]) sel = 2'd2;
    end

    always_comb begin
        state_d = state_q;
        vect_d  = vect_q;
        ack_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (cand != 4'd0) begin
                    state_d = S_REQ;
                    vect_d  = sel;
                end
            end
            S_REQ: begin
                // A vanished request wins over an acknowledge in the same cycle.
                if (withdraw) begin
                    state_d = S_IDLE;
                end else if (bus.ack) begin
                    state_d = S_SERV;
                    ack_clr = 4'b0001 << vect_q;
                end
            end
            S_SERV: begin
                if (bus.reti) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign irq_d  = (state_d == S_REQ);
    assign sw_clr = wr_pend ? bus.o[3:0] : 4'd0;
    // New events are ORed in after the clears so a coincident event always survives.
    assign pend_d = (pend_q & ~(sw_clr | ack_clr)) | {bus.ev, tick_wrap};
    assign mask_d = wr_mask ? bus.o[3:0] : mask_q;
    assign en_d   = wr_ctrl ? bus.o[0] : en_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            en_q    <= 1'b0;
            vect_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            vect_q  <= vect_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        bus.p = 8'h00;
        case (bus.a)
            A_IMASK: bus.p = {4'h0, mask_q};
            A_IPEND: bus.p = {4'h0, pend_q};
            A_ICTRL: bus.p = {(state_q == S_SERV), 6'b000000, en_q};
            default: bus.p = 8'h00;
        endcase
    end

    assign bus.irq  = irq_q;
    assign bus.vect = vect_q;
endmodule
